piano_seq_ctrl: RTL and testbench
=================================

Name: piano_seq_ctrl

Overview:
UART-driven monophonic note sequencer, the next generation of the keyboard-to-audio FSM.
- Pops one key byte at a time from the UART RX FIFO and echoes it to the UART TX FIFO.
- Looks up the tone half-period in the external scale ROM and plays the note for a rotary-adjustable duration.
- Streams signed square-wave samples to the I2S FIFO at a fixed sample rate and mirrors the tone on a 1-bit PWM pin.

Parameters:
SAMPLE_W, 20, I2S sample width (two's complement)
PERIOD_W, 24, tone half-period width in clk cycles
LEN_W, 27, note-duration counter width
LEN_DEFAULT, 25000000, note duration after reset (clk cycles)
LEN_STEP, 1250000, duration change per rotary event
LEN_MIN, 1250000, duration lower bound
LEN_MAX, 125000000, duration upper bound (must be < 2^LEN_W)
SAMPLE_DIV, 2834, clk cycles per I2S sample (125 MHz / 44.1 kHz)
AMPL, 262143, sample magnitude (must be < 2^(SAMPLE_W-1))
RETRIGGER, 1, 1: a new byte during PLAY cuts the current note; 0: bytes queue in the RX FIFO until the note ends

Ports:
clk  in  1  125 MHz clock
rst  in  1  synchronous, active-low reset
rotary_event  in  1  one-cycle pulse per rotary detent
rotary_left  in  1  direction, valid with rotary_event (1 = shorten)
ua_receive_dout  in  8  RX FIFO data, valid the cycle after rd_en
ua_receive_empty  in  1  RX FIFO empty
ua_receive_rd_en  out  1  RX FIFO pop
ua_transmit_din  out  8  echo byte
ua_transmit_wr_en  out  1  TX FIFO push
ua_transmit_full  in  1  TX FIFO full
rom_address  out  8  scale ROM address (latched key byte)
rom_period  in  PERIOD_W  combinational ROM data, same cycle; 0 = rest
i2s_din  out  SAMPLE_W  sample to I2S FIFO
i2s_wr_en  out  1  I2S FIFO push
i2s_full  in  1  I2S FIFO full
audio_pwm  out  1  square wave, low when silent
note_active  out  1  high in PLAY
sample_drop  out  1  one-cycle pulse when a sample tick is lost to i2s_full

Behaviour:
- Reset (rst=0 at a clk edge): FSM→IDLE; every output 0; duration register = LEN_DEFAULT; all counters 0; the wave level register = 0.
- Reset mid-note aborts the note at once. RX FIFO contents are untouched.
- FSM states: IDLE, POP, LATCH, ECHO, PLAY.
- IDLE: if !ua_receive_empty → POP.
- POP: ua_receive_rd_en=1 for exactly this cycle → LATCH.
- LATCH: key ← ua_receive_dout; → ECHO.
- ECHO:
  - rom_address = key.
  - If !ua_transmit_full: ua_transmit_wr_en=1, din=key for one cycle; latch period ← rom_period and len ← duration register; → PLAY.
  - If full: stall in ECHO with wr_en=0.
- PLAY:
  - note_active=1; note counter counts 0..len-1, then → IDLE.
  - RETRIGGER=1 and !ua_receive_empty: → POP on the next cycle; the note stops immediately.
- Pipeline latency: byte accepted (POP) → echo push is 2 cycles minimum. First PLAY cycle follows the echo push.
- Square wave:
  - On PLAY entry, phase counter = 0 and level = 0.
  - When phase reaches period-1, phase clears and level toggles.
  - period = 0 means rest: level stays 0.
  - audio_pwm = level & note_active.
- Sample path, free-running from reset, independent of the FSM:
  - The tick counter counts 0..SAMPLE_DIV-1; a tick fires at SAMPLE_DIV-1.
  - On a tick with !i2s_full: i2s_wr_en=1 for one cycle with i2s_din as follows.
    - +AMPL if note_active and level=1.
    - -AMPL if note_active, level=0 and period≠0.
    - 0 otherwise.
  - On a tick with i2s_full: no write; sample_drop=1 for one cycle. The sample is not retried.
- Rotary:
  - On rotary_event, duration ± LEN_STEP, saturating at LEN_MIN / LEN_MAX; left subtracts.
  - Arithmetic is done at LEN_W+1 bits before clamping.
  - The new value applies only to the next note; a playing note keeps its latched len.
  - If rotary_event coincides with an ECHO→PLAY transition, the note latches the pre-update value.
- Any byte value is legal. The ROM defines the period; unmapped keys are expected to return 0 (rest).

Decomposition:
- Package piano_pkg: FSM state enum (3-bit), sample sign constants, and the LEN_MIN/LEN_MAX/LEN_STEP defaults.
- One sub-module, piano_square_gen, holds the phase counter, level register and period latch. Its inputs are start, period and active; its outputs are level and audio_pwm.
- The FSM, duration register and sample ticker live in the top module.

Test Plan:
- Byte 0x41 in RX FIFO, ROM returns period 1000, TX not full: rd_en pulse, then echo 0x41 two cycles later; note_active high exactly 25000000 cycles; audio_pwm toggles every 1000 cycles.
- ua_transmit_full held high 50 cycles in ECHO: no wr_en, no PLAY until full drops, then a single echo push.
- Two rotary-left events, then a note: that note lasts 22500000 cycles. 25 left events clamp duration at 1250000; 100 right events clamp at 125000000.
- RETRIGGER=1, second byte arrives mid-note: note cut, second note starts with a fresh phase (level=0). With RETRIGGER=0 the second byte is popped only after the first note ends.
- Sample stream: ticks every 2834 cycles carry ±262143 while a note with period≠0 plays, 0 in IDLE and for period=0. i2s_full high across one tick gives one sample_drop pulse and no wr_en.
- rst low during PLAY: next cycle all outputs 0, state IDLE, duration back to 25000000, and the queued RX byte is still popped afterwards.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared types and rotary-duration defaults
// for the piano note sequencer.
package piano_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_ECHO,
        S_PLAY
    } state_t;

    typedef enum logic [1:0] {
        SGN_ZERO,
        SGN_POS,
        SGN_NEG
    } sign_t;

    localparam int LEN_STEP_DEF = 1250000;
    localparam int LEN_MIN_DEF  = 1250000;
    localparam int LEN_MAX_DEF  = 125000000;

endpackage

// File: rtl/piano_square_gen.sv
// Square-wave generator: period latch, phase counter
// and level register, restarted on every note.
module piano_square_gen
    import piano_pkg::*;
#(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [PERIOD_W-1:0] period,
    input  logic                active,
    output logic                level,
    output logic                audio_pwm
);

    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] phase;

    always_ff @(posedge clk) begin
        if (!rst) begin
            period_q <= '0;
            phase    <= '0;
            level    <= 1'b0;
        end else if (start) begin
            period_q <= period;
            phase    <= '0;
            level    <= 1'b0;
        end else if (active && period_q != '0) begin
            if (phase == period_q - PERIOD_W'(1)) begin
                phase <= '0;
                level <= ~level;
            end else begin
                phase <= phase + PERIOD_W'(1);
            end
        end
    end

    assign audio_pwm = level & active;

endmodule

// File: rtl/piano_seq_ctrl.sv
// UART-driven monophonic note sequencer with echo,
// adjustable note length, I2S sample stream and PWM.
module piano_seq_ctrl
    import piano_pkg::*;
#(
    parameter int SAMPLE_W    = 20,
    parameter int PERIOD_W    = 24,
    parameter int LEN_W       = 27,
    parameter int LEN_DEFAULT = 25000000,
    parameter int LEN_STEP    = LEN_STEP_DEF,
    parameter int LEN_MIN     = LEN_MIN_DEF,
    parameter int LEN_MAX     = LEN_MAX_DEF,
    parameter int SAMPLE_DIV  = 2834,
    parameter int AMPL        = 262143,
    parameter int RETRIGGER   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rotary_event,
    input  logic                rotary_left,
    input  logic [7:0]          ua_receive_dout,
    input  logic                ua_receive_empty,
    output logic                ua_receive_rd_en,
    output logic [7:0]          ua_transmit_din,
    output logic                ua_transmit_wr_en,
    input  logic                ua_transmit_full,
    output logic [7:0]          rom_address,
    input  logic [PERIOD_W-1:0] rom_period,
    output logic [SAMPLE_W-1:0] i2s_din,
    output logic                i2s_wr_en,
    input  logic                i2s_full,
    output logic                audio_pwm,
    output logic                note_active,
    output logic                sample_drop
);

    localparam int TICK_W = $clog2(SAMPLE_DIV + 1);
    localparam int WIDE_W = LEN_W + 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
    localparam logic [WIDE_W-1:0] STEP_X = WIDE_W'(LEN_STEP);
    localparam logic [WIDE_W-1:0] MIN_X  = WIDE_W'(LEN_MIN);
    localparam logic [WIDE_W-1:0] MAX_X  = WIDE_W'(LEN_MAX);
    localparam logic [SAMPLE_W-1:0] POS  = SAMPLE_W'(AMPL);
    localparam logic [SAMPLE_W-1:0] NEG  = SAMPLE_W'(-AMPL);

    state_t              state;
    state_t              nxt;
    sign_t               sign;
    logic [7:0]          key;
    logic [LEN_W-1:0]    dur;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    note_cnt;
    logic [WIDE_W-1:0]   dur_up;
    logic [WIDE_W-1:0]   dur_dn;
    logic [TICK_W-1:0]   tick_cnt;
    logic                tone;
    logic                level;
    logic                tick;
    logic                note_end;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= nxt;
        end
    end

    assign note_end = note_cnt == len_q - LEN_W'(1);

    always_comb begin
        nxt               = state;
        ua_receive_rd_en  = 1'b0;
        ua_transmit_wr_en = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!ua_receive_empty) nxt = S_POP;
            end
            S_POP: begin
                ua_receive_rd_en = 1'b1;
                nxt              = S_LATCH;
            end
            S_LATCH: nxt = S_ECHO;
            S_ECHO: begin
                if (!ua_transmit_full) begin
                    ua_transmit_wr_en = 1'b1;
                    nxt               = S_PLAY;
                end
            end
            S_PLAY: begin
                if (RETRIGGER != 0 && !ua_receive_empty) begin
                    nxt = S_POP;
                end else if (note_end) begin
                    nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    assign note_active     = state == S_PLAY;
    assign rom_address     = key;
    assign ua_transmit_din = ua_transmit_wr_en ? key : 8'h00;

    always_ff @(posedge clk) begin
        if (!rst) begin
            key      <= '0;
            len_q    <= '0;
            note_cnt <= '0;
            tone     <= 1'b0;
        end else begin
            if (state == S_LATCH) key <= ua_receive_dout;
            if (ua_transmit_wr_en) begin
                len_q    <= dur;
                note_cnt <= '0;
                tone     <= rom_period != '0;
            end else if (state == S_PLAY) begin
                note_cnt <= note_cnt + LEN_W'(1);
            end
        end
    end

    // One extra bit catches both borrow and overflow before clamping.
    assign dur_up = {1'b0, dur} + STEP_X;
    assign dur_dn = {1'b0, dur} - STEP_X;

    always_ff @(posedge clk) begin
        if (!rst) begin
            dur <= LEN_W'(LEN_DEFAULT);
        end else if (rotary_event) begin
            if (rotary_left) begin
                dur <= (dur_dn[LEN_W] || dur_dn < MIN_X)
                     ? LEN_W'(LEN_MIN) : dur_dn[LEN_W-1:0];
            end else begin
                dur <= (dur_up > MAX_X)
                     ? LEN_W'(LEN_MAX) : dur_up[LEN_W-1:0];
            end
        end
    end

    piano_square_gen #(
        .PERIOD_W (PERIOD_W)
    ) u_sq (
        .clk       (clk),
        .rst       (rst),
        .start     (ua_transmit_wr_en),
        .period    (rom_period),
        .active    (note_active),
        .level     (level),
        .audio_pwm (audio_pwm)
    );

    assign tick = tick_cnt == TICK_LAST;

    always_ff @(posedge clk) begin
        if (!rst || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    always_comb begin
        sign = SGN_ZERO;
        if (note_active) begin
            if (level) begin
                sign = SGN_POS;
            end else if (tone) begin
                sign = SGN_NEG;
            end
        end
    end

    assign i2s_wr_en   = tick & ~i2s_full;
    assign sample_drop = tick & i2s_full;

    always_comb begin
        i2s_din = '0;
        if (i2s_wr_en) begin
            unique case (sign)
                SGN_POS: i2s_din = POS;
                SGN_NEG: i2s_din = NEG;
                default: i2s_din = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_piano_seq_ctrl.sv
// Scoreboard bench for piano_seq_ctrl with scaled-down
// durations and sample divider.
module tb_piano_seq_ctrl;

    localparam int SW   = 20;
    localparam int PW   = 24;
    localparam int LW   = 27;
    localparam int DIV  = 50;
    localparam int A    = 262143;
    localparam int LDEF = 200;

    typedef struct {
        logic [7:0] b;
        int         lat;
    } echo_t;

    typedef struct {
        int len;
        int per;
    } note_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rotary_event = 1'b0;
    logic          rotary_left = 1'b0;
    logic [7:0]    ua_receive_dout = 8'h00;
    logic          ua_receive_empty = 1'b1;
    logic          ua_receive_rd_en;
    logic [7:0]    ua_transmit_din;
    logic          ua_transmit_wr_en;
    logic          ua_transmit_full = 1'b0;
    logic [7:0]    rom_address;
    logic [PW-1:0] rom_period;
    logic [SW-1:0] i2s_din;
    logic          i2s_wr_en;
    logic          i2s_full = 1'b0;
    logic          audio_pwm;
    logic          note_active;
    logic          sample_drop;

    logic [7:0]    dout2 = 8'h00;
    logic          empty2 = 1'b1;
    logic          rd_en2;
    logic [7:0]    din2;
    logic          wr_en2;
    logic [7:0]    addr2;
    logic [PW-1:0] period2;
    logic [SW-1:0] i2s_din2;
    logic          i2s_wr_en2;
    logic          pwm2;
    logic          note_active2;
    logic          drop2;
    logic          zero = 1'b0;

    int tests = 0;
    int fails = 0;
    int tc = 0;
    int cyc = 0;
    int rd_cyc = 0;

    echo_t      echo_q[$];
    note_t      note_q[$];
    note_t      note2_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] rx2_q[$];

    function automatic logic [PW-1:0] rom(input logic [7:0] a);
        case (a)
            8'h41:   rom = PW'(12);
            8'h42:   rom = PW'(7);
            8'h43:   rom = PW'(5);
            default: rom = '0;
        endcase
    endfunction

    assign rom_period = rom(rom_address);
    assign period2    = rom(addr2);

    piano_seq_ctrl #(
        .SAMPLE_W(SW), .PERIOD_W(PW), .LEN_W(LW),
        .LEN_DEFAULT(LDEF), .LEN_STEP(20), .LEN_MIN(20),
        .LEN_MAX(400), .SAMPLE_DIV(DIV), .AMPL(A),
        .RETRIGGER(1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .rotary_event      (rotary_event),
        .rotary_left       (rotary_left),
        .ua_receive_dout   (ua_receive_dout),
        .ua_receive_empty  (ua_receive_empty),
        .ua_receive_rd_en  (ua_receive_rd_en),
        .ua_transmit_din   (ua_transmit_din),
        .ua_transmit_wr_en (ua_transmit_wr_en),
        .ua_transmit_full  (ua_transmit_full),
        .rom_address       (rom_address),
        .rom_period        (rom_period),
        .i2s_din           (i2s_din),
        .i2s_wr_en         (i2s_wr_en),
        .i2s_full          (i2s_full),
        .audio_pwm         (audio_pwm),
        .note_active       (note_active),
        .sample_drop       (sample_drop)
    );

    piano_seq_ctrl #(
        .SAMPLE_W(SW), .PERIOD_W(PW), .LEN_W(LW),
        .LEN_DEFAULT(LDEF), .LEN_STEP(20), .LEN_MIN(20),
        .LEN_MAX(400), .SAMPLE_DIV(DIV), .AMPL(A),
        .RETRIGGER(0)
    ) dut_q (
        .clk               (clk),
        .rst               (rst),
        .rotary_event      (zero),
        .rotary_left       (zero),
        .ua_receive_dout   (dout2),
        .ua_receive_empty  (empty2),
        .ua_receive_rd_en  (rd_en2),
        .ua_transmit_din   (din2),
        .ua_transmit_wr_en (wr_en2),
        .ua_transmit_full  (zero),
        .rom_address       (addr2),
        .rom_period        (period2),
        .i2s_din           (i2s_din2),
        .i2s_wr_en         (i2s_wr_en2),
        .i2s_full          (zero),
        .audio_pwm         (pwm2),
        .note_active       (note_active2),
        .sample_drop       (drop2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int n);
        tests++;
        fails++;
        $display("FAIL %s: no response after %0d cycles", name, n);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        tc <= !rst ? 0 : (tc == DIV - 1 ? 0 : tc + 1);
        if (ua_receive_rd_en && rx_q.size() > 0) begin
            ua_receive_dout  <= rx_q.pop_front();
            ua_receive_empty <= rx_q.size() == 0;
        end
        if (rd_en2 && rx2_q.size() > 0) begin
            dout2  <= rx2_q.pop_front();
            empty2 <= rx2_q.size() == 0;
        end
    end

    task automatic play(input logic [7:0] b, input int lat,
                        input int len);
        echo_t e;
        note_t n;
        e.b   = b;
        e.lat = lat;
        n.len = len;
        n.per = int'(rom(b));
        echo_q.push_back(e);
        note_q.push_back(n);
        rx_q.push_back(b);
        ua_receive_empty = 1'b0;
    endtask

    task automatic rot(input logic left, input int n);
        repeat (n) begin
            rotary_left  = left;
            rotary_event = 1'b1;
            tick();
            rotary_event = 1'b0;
            tick();
        end
    endtask

    task automatic wait_start(input int limit);
        int n = 0;
        while (!note_active && n < limit) begin
            tick();
            n++;
        end
        if (!note_active) timeout("note_start", n);
    endtask

    task automatic wait_note(input int limit);
        int n = 0;
        while (!note_active && n < limit) begin
            tick();
            n++;
        end
        while (note_active && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) timeout("note_done", n);
        repeat (2) tick();
    endtask

    task automatic chk_reset();
        chk("reset_outputs",
            {ua_receive_rd_en, ua_transmit_wr_en, ua_transmit_din,
             rom_address, i2s_din, i2s_wr_en, audio_pwm,
             note_active, sample_drop}, 64'd0);
    endtask

    always @(negedge clk) begin
        echo_t e;
        cyc++;
        if (ua_receive_rd_en) rd_cyc = cyc;
        if (ua_transmit_wr_en) begin
            chk("echo_queue", echo_q.size() > 0, 1);
            if (echo_q.size() > 0) begin
                e = echo_q.pop_front();
                chk("echo_byte", ua_transmit_din, e.b);
                chk("echo_latency", cyc - rd_cyc, e.lat);
            end
        end
    end

    int         k = 0;
    bit         in_note = 1'b0;
    note_t      cur = '{-1, 0};
    logic       lvl;
    logic [SW-1:0] exp_s;

    always @(negedge clk) begin
        if (note_active) begin
            if (!in_note) begin
                in_note = 1'b1;
                k = 0;
                chk("note_queue", note_q.size() > 0, 1);
                if (note_q.size() > 0) cur = note_q.pop_front();
                else cur = '{-1, 0};
            end else begin
                k++;
            end
        end else if (in_note) begin
            in_note = 1'b0;
            chk("note_len", k + 1, cur.len);
        end
        lvl = note_active && cur.per != 0
              && ((k / cur.per) % 2 == 1);
        chk("pwm", audio_pwm, lvl);
        if (tc == DIV - 1) begin
            if (i2s_full) begin
                chk("drop_pulse", sample_drop, 1);
                chk("drop_no_wr", i2s_wr_en, 0);
            end else begin
                if (!note_active || cur.per == 0) exp_s = '0;
                else if (lvl) exp_s = SW'(A);
                else exp_s = SW'(-A);
                chk("sample_wr", i2s_wr_en, 1);
                chk("sample_val", i2s_din, exp_s);
            end
        end else begin
            chk("stray_sample", {i2s_wr_en, sample_drop}, 0);
        end
    end

    int    k2 = 0;
    bit    in_note2 = 1'b0;
    note_t cur2 = '{-1, 0};

    always @(negedge clk) begin
        if (note_active2) begin
            if (!in_note2) begin
                in_note2 = 1'b1;
                k2 = 0;
                chk("q_note_queue", note2_q.size() > 0, 1);
                if (note2_q.size() > 0) cur2 = note2_q.pop_front();
                else cur2 = '{-1, 0};
            end else begin
                k2++;
            end
        end else if (in_note2) begin
            in_note2 = 1'b0;
            chk("q_note_len", k2 + 1, cur2.len);
            chk("q_rx_held", rx2_q.size() + (empty2 ? 0 : 0), cur2.per);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) tick();
        chk_reset();
        rst = 1'b1;
        repeat (2) tick();

        // default-length note with echo two cycles after the pop
        play(8'h41, 2, LDEF);
        wait_note(1000);

        // echo stalls on TX full; rotary on the push cycle is not seen
        ua_transmit_full = 1'b1;
        play(8'h42, 52, LDEF);
        n = 0;
        do begin
            tick();
            n++;
        end while (!ua_receive_rd_en && n < 20);
        if (!ua_receive_rd_en) timeout("tx_full_pop", n);
        repeat (52) tick();
        ua_transmit_full = 1'b0;
        rotary_left      = 1'b1;
        rotary_event     = 1'b1;
        tick();
        rotary_event = 1'b0;
        wait_note(1000);

        rot(1'b1, 2);
        play(8'h43, 2, 140);
        wait_note(1000);

        rot(1'b1, 25);
        play(8'h20, 2, 20);
        wait_note(1000);

        rot(1'b0, 100);
        play(8'h20, 2, 400);
        wait_note(1000);

        play(8'h41, 2, 400);
        wait_start(50);
        n = 0;
        while (tc != DIV - 3 && n < 2 * DIV) begin
            tick();
            n++;
        end
        if (tc != DIV - 3) timeout("drop_align", n);
        i2s_full = 1'b1;
        repeat (5) tick();
        i2s_full = 1'b0;
        wait_note(1000);

        // a byte arriving mid-note cuts it; next note restarts phase
        play(8'h42, 2, 31);
        wait_start(50);
        repeat (30) tick();
        play(8'h43, 2, 400);
        tick();
        wait_note(1000);

        // reset mid-note with a byte waiting in the RX FIFO
        rot(1'b1, 1);
        play(8'h41, 2, 21);
        wait_start(50);
        repeat (20) tick();
        echo_q.push_back('{8'h42, 2});
        note_q.push_back('{LDEF, 7});
        rst = 1'b0;
        rx_q.push_back(8'h42);
        ua_receive_empty = 1'b0;
        tick();
        chk_reset();
        rst = 1'b1;
        wait_note(1000);

        // without retrigger the second byte waits for the first note
        note2_q.push_back('{LDEF, 1});
        note2_q.push_back('{LDEF, 0});
        rx2_q.push_back(8'h41);
        rx2_q.push_back(8'h42);
        empty2 = 1'b0;
        n = 0;
        while ((note2_q.size() != 0 || note_active2 || n < 5)
               && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) timeout("q_notes", n);
        repeat (3) tick();

        chk("echo_drain", echo_q.size(), 0);
        chk("note_drain", note_q.size(), 0);
        chk("q_note_drain", note2_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
